// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit add/subtract, CHUNK bits per cycle, least significant chunk first.
// Latency: out_valid rises WIDTH/CHUNK edges after accept; initiation interval WIDTH/CHUNK+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. SEQ_CHUNK_ADDER_SAT_EN saturates on overflow.
module seq_chunk_adder #(
    parameter int WIDTH = 16,   // multiple of CHUNK
    parameter int CHUNK = 4     // 1 <= CHUNK <= WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // Operands shift right one chunk per RUN edge so the active chunk is always at bit 0.
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    logic             a_msb;   // sign of the original A selects the saturation direction
`endif

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;  // carry into the top bit of the chunk (only meaningful on the last chunk)

    // Accept only in IDLE and never while reset is held.
    assign in_ready = (state == IDLE) && !rst;

    // CHUNK-bit ripple chain over the low chunk of the shifted operands.
    always_comb begin : ripple
        logic c;
        c          = carry;
        chunk_sum  = '0;
        chunk_cmsb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                chunk_cmsb = c;
            end
            chunk_sum[i] = opa[i] ^ opb[i] ^ c;
            c            = (opa[i] & opb[i]) | (c & (opa[i] ^ opb[i]));
        end
        chunk_cout = c;
    end

    // Control FSM, operand/carry registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
            a_msb     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + ~cin: inverted borrow-in doubles as the +1.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= RUN;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
                        a_msb <= a[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    sum[int'(cnt)*CHUNK +: CHUNK] <= chunk_sum;
                    carry <= chunk_cout;
                    opa   <= opa >> CHUNK;
                    opb   <= opb >> CHUNK;
                    if (cnt == LAST) begin
                        cout      <= chunk_cout;
                        ovf       <= chunk_cmsb ^ chunk_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
                        // Later assignment overrides the chunk write above.
                        if (chunk_cmsb ^ chunk_cout) begin
                            sum <= a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed and random operations against an arithmetic reference model.
// Covers 16/4 main configuration plus 8/8 and 8/1 degenerate chunking.
// Result hold under backpressure, back-to-back issue and reset abort are exercised.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // main DUT, WIDTH=16 CHUNK=4
    logic        rst, in_valid, cin, sub, out_ready;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] a, b, sum;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // degenerate DUTs share 8-bit stimulus
    logic       d_in_valid, d_cin, d_sub, d_out_ready;
    logic [7:0] d_a, d_b;
    logic       w_in_ready, w_out_valid, w_cout, w_ovf;
    logic [7:0] w_sum;
    logic       s_in_ready, s_out_valid, s_cout, s_ovf;
    logic [7:0] s_sum;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(w_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(w_out_valid), .out_ready(d_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(s_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(s_out_valid), .out_ready(d_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  input bit c, input bit s,
                                  output longint rs, output bit rc, output bit rv);
        longint m, half, sa, sb, raw, sraw, lc;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        lc   = c ? longint'(1) : longint'(0);
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (s) begin
            raw  = ua - ub - lc;
            rc   = (raw >= 0);
            sraw = sa - sb - lc;
        end else begin
            raw  = ua + ub + lc;
            rc   = (raw > m);
            sraw = sa + sb + lc;
        end
        rs = raw & m;
        rv = (sraw >= half) || (sraw < -half);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
        if (rv) rs = (sa < 0) ? half : half - 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 16/4 DUT with optional output backpressure.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                          input logic tc, input logic ts, input int hold);
        longint es;
        bit     ec, ev;
        int     lat, guard;
        model(16, longint'(ta), longint'(tbv), tc, ts, es, ec, ev);
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("accept_ready", 32'(in_ready), 32'(1));
        a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("busy_in_ready", 32'(in_ready), 32'(0));
            // inputs must be ignored while busy; out_ready outside DONE has no effect
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            out_ready = (lat < 3) ? 1'($urandom) : 1'b0;
            tick();
            lat++;
        end
        out_ready = 1'b0;
        chk("latency", 32'(lat), 32'(4));
        chk("sum", 32'(sum), 32'(es[15:0]));
        chk("cout", 32'(cout), 32'(ec));
        chk("ovf", 32'(ovf), 32'(ev));
        repeat (hold) begin
            tick();
            chk("hold_sum", 32'(sum), 32'(es[15:0]));
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'(0));
        chk("post_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] pa [4];
        logic [7:0] pb [4];
        logic       pc [4];
        logic       ps [4];
        longint     es8;
        bit         ec8, ev8;
        int         lw, ls;
        logic [7:0] cw_sum, cs_sum;
        logic       cw_cout, cw_ovf, cs_cout, cs_ovf;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_w_valid", 32'(w_out_valid), 32'(0));
        chk("rst_s_valid", 32'(s_out_valid), 32'(0));
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'(1));

        // directed cases
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);  // add wrap
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);  // positive overflow
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);  // negative overflow via subtract
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);  // borrow
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);  // borrow-in, no borrow out
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 10); // backpressure
        run_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 0);  // back-to-back issue

        // reset in the middle of an operation
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();          // first RUN edge
        rst = 1'b1;
        tick();          // second RUN edge, aborted
        chk("abort_in_ready_rst", 32'(in_ready), 32'(0));
        chk("abort_valid", 32'(out_valid), 32'(0));
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_sum", 32'(sum), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        chk("abort_ovf", 32'(ovf), 32'(0));
        repeat (8) begin
            tick();
            chk("abort_no_valid", 32'(out_valid), 32'(0));
        end

        // random operations
        repeat (40) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // degenerate chunking on 8-bit instances
        pa[0] = 8'h80; pb[0] = 8'h80; pc[0] = 1'b0; ps[0] = 1'b0;
        pa[1] = 8'h0F; pb[1] = 8'h01; pc[1] = 1'b0; ps[1] = 1'b0;
        for (int p = 2; p < 4; p++) begin
            pa[p] = 8'($urandom); pb[p] = 8'($urandom);
            pc[p] = 1'($urandom); ps[p] = 1'($urandom);
        end
        for (int p = 0; p < 4; p++) begin
            model(8, longint'(pa[p]), longint'(pb[p]), pc[p], ps[p], es8, ec8, ev8);
            chk("deg_w_ready", 32'(w_in_ready), 32'(1));
            chk("deg_s_ready", 32'(s_in_ready), 32'(1));
            d_a = pa[p]; d_b = pb[p]; d_cin = pc[p]; d_sub = ps[p]; d_in_valid = 1'b1;
            tick();
            d_in_valid = 1'b0;
            lw = -1; ls = -1;
            cw_sum = '0; cw_cout = 1'b0; cw_ovf = 1'b0;
            cs_sum = '0; cs_cout = 1'b0; cs_ovf = 1'b0;
            for (int cyc = 1; cyc <= 12; cyc++) begin
                d_a = 8'($urandom); d_b = 8'($urandom);
                tick();
                if (w_out_valid && lw < 0) begin
                    lw = cyc; cw_sum = w_sum; cw_cout = w_cout; cw_ovf = w_ovf;
                end
                if (s_out_valid && ls < 0) begin
                    ls = cyc; cs_sum = s_sum; cs_cout = s_cout; cs_ovf = s_ovf;
                end
            end
            chk("deg_w_latency", 32'(lw), 32'(1));
            chk("deg_w_sum", 32'(cw_sum), 32'(es8[7:0]));
            chk("deg_w_cout", 32'(cw_cout), 32'(ec8));
            chk("deg_w_ovf", 32'(cw_ovf), 32'(ev8));
            chk("deg_s_latency", 32'(ls), 32'(8));
            chk("deg_s_sum", 32'(cs_sum), 32'(es8[7:0]));
            chk("deg_s_cout", 32'(cs_cout), 32'(ec8));
            chk("deg_s_ovf", 32'(cs_ovf), 32'(ev8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
